// File: rtl/sar_search_ctrl_if.sv
// Comparator-side bundle for the successive-approximation search controller.
// The controller takes the master modport; the comparator/environment takes the slave modport.
interface sar_search_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cmp_greater;
    logic             cmp_lesser;
    logic             cmp_equal;
    logic [WIDTH-1:0] trial;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             found;
    logic             err;

    modport master (
        input  start, cmp_greater, cmp_lesser, cmp_equal,
        output trial, busy, done, result, found, err
    );

    modport slave (
        output start, cmp_greater, cmp_lesser, cmp_equal,
        input  trial, busy, done, result, found, err
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// Successive-approximation search controller: walks a trial value through a binary search
// against an external comparator and reports the largest value not above the target.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | trial=0, waiting for start
//   S_TRIAL  | binary search, one bit per trial, held SETTLE+1 cycles
//   S_VERIFY | final trial of the resolved value, decides found
//   S_DONE   | one-cycle done pulse, then back to idle
module sar_search_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    sar_search_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TRIAL  = 2'd1,
        S_VERIFY = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int               IW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0]    IDX_TOP    = IW'(WIDTH - 1);
    localparam logic [3:0]       CNT_LAST   = 4'(SETTLE);
    localparam logic [WIDTH-1:0] TRIAL_INIT = WIDTH'(1) << (WIDTH - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             found_q, found_d;
    logic             err_q, err_d;

    logic             flags_ok;
    logic             sample;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial_upd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            trial_q  <= '0;
            result_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        trial_d  = trial_q;
        result_d = result_q;
        found_d  = found_q;
        err_d    = err_q;

        flags_ok  = $onehot({bus.cmp_greater, bus.cmp_lesser, bus.cmp_equal});
        sample    = (cnt_q == CNT_LAST);
        bit_mask  = WIDTH'(1) << idx_q;
        // greater means the trial overshot: drop the bit under test, otherwise keep it
        trial_upd = bus.cmp_greater ? (trial_q & ~bit_mask) : trial_q;

        case (state_q)
            S_IDLE: begin
                trial_d = '0;
                if (bus.start) begin
                    state_d  = S_TRIAL;
                    idx_d    = IDX_TOP;
                    cnt_d    = '0;
                    trial_d  = TRIAL_INIT;
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                end
            end

            S_TRIAL: begin
                if (!sample) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    cnt_d = '0;
                    if (!flags_ok) begin
                        state_d  = S_DONE;
                        result_d = trial_q;
                        found_d  = 1'b0;
                        err_d    = 1'b1;
                        trial_d  = '0;
                    end else if (bus.cmp_equal) begin
                        state_d  = S_DONE;
                        result_d = trial_q;
                        found_d  = 1'b1;
                        trial_d  = '0;
                    end else if (idx_q == '0) begin
                        state_d = S_VERIFY;
                        trial_d = trial_upd;
                    end else begin
                        idx_d   = idx_q - IW'(1);
                        trial_d = trial_upd | (bit_mask >> 1);
                    end
                end
            end

            S_VERIFY: begin
                if (!sample) begin
                    cnt_d = cnt_q + 4'd1;
                end else begin
                    // the last trial also catches target=0 and targets beyond the range
                    cnt_d    = '0;
                    state_d  = S_DONE;
                    result_d = trial_q;
                    trial_d  = '0;
                    found_d  = flags_ok & bus.cmp_equal;
                    err_d    = ~flags_ok;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                trial_d = '0;
            end

            default: begin
                state_d = S_IDLE;
                trial_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.busy   = (state_q == S_TRIAL) || (state_q == S_VERIFY);
        bus.done   = (state_q == S_DONE);
        bus.trial  = trial_q;
        bus.result = result_q;
        bus.found  = found_q;
        bus.err    = err_q;
    end
endmodule
